// File: rtl/sm_datapath_if.sv
// rtl/sm_datapath_if.sv - strobe/operand bus between the multiplier controller and its datapath
//
// Purpose: groups the controller-to-datapath strobes and operands and the
// datapath status returned to the controller.
// Signals:
//   md_in   [NUM_BITS]        multiplicand source value
//   mr_in   [NUM_BITS]        multiplier source value
//   mdld, mrld                load MD / MR
//   rsload, rsclear, rsshr    running-sum add / clear / shift strobes
//   mr      [NUM_BITS]        MR register contents
//   product [2*NUM_BITS]      RS register contents
//   nshift  [clog2(N+1)]      shifts since last clear, saturating at NUM_BITS
//   err                       sticky protocol-violation flag
// Modports: master (controller side), slave (datapath side).
interface sm_datapath_if #(
  parameter int NUM_BITS = 4
);
  localparam int CW = $clog2(NUM_BITS + 1);

  logic [NUM_BITS-1:0]   md_in;
  logic [NUM_BITS-1:0]   mr_in;
  logic                  mdld;
  logic                  mrld;
  logic                  rsload;
  logic                  rsclear;
  logic                  rsshr;
  logic [NUM_BITS-1:0]   mr;
  logic [2*NUM_BITS-1:0] product;
  logic [CW-1:0]         nshift;
  logic                  err;

  modport master (
    output md_in, mr_in, mdld, mrld, rsload, rsclear, rsshr,
    input  mr, product, nshift, err
  );

  modport slave (
    input  md_in, mr_in, mdld, mrld, rsload, rsclear, rsshr,
    output mr, product, nshift, err
  );
endinterface

// File: rtl/sm_datapath.sv
// rtl/sm_datapath.sv - shift-and-add multiplier datapath (MD, MR, RS, carry, shift count)
//
// Purpose: holds the multiplicand, multiplier and running-sum registers and
// executes the controller strobes; product = MD*MR after the standard
// clear / (add-if-bit, shift) x NUM_BITS sequence.
// Ports:
//   clk   in   single clock, all state updates on the rising edge
//   rst   in   synchronous active-high reset, overrides every strobe
//   bus   sm_datapath_if.slave (operands, strobes, mr/product/nshift/err)
// Optional feature: define SM_DP_PROTOCOL_CHECK_EN to build the sticky
// protocol checker driving err; otherwise err is tied low.
module sm_datapath #(
  parameter int NUM_BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  sm_datapath_if.slave  bus
);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] NS_MAX = CW'(NUM_BITS);

  logic [NUM_BITS-1:0]   md_q, md_d;
  logic [NUM_BITS-1:0]   mr_q, mr_d;
  logic [2*NUM_BITS-1:0] rs_q, rs_d;
  logic                  c_q, c_d;
  logic [CW-1:0]         ns_q, ns_d;
  logic [NUM_BITS:0]     sum;
  logic [CW-1:0]         ns_inc;

  // Adder always sees pre-edge MD, so an MD load lands one cycle before use.
  assign sum    = {1'b0, rs_q[2*NUM_BITS-1:NUM_BITS]} + {1'b0, md_q};
  assign ns_inc = (ns_q == NS_MAX) ? ns_q : ns_q + 1'b1;

  always_comb begin
    md_d = bus.mdld ? bus.md_in : md_q;
    mr_d = bus.mrld ? bus.mr_in : mr_q;
    rs_d = rs_q;
    c_d  = c_q;
    ns_d = ns_q;
    if (bus.rsclear) begin
      rs_d = '0;
      c_d  = 1'b0;
      ns_d = '0;
    end else begin
      unique case ({bus.rsload, bus.rsshr})
        2'b10: begin
          c_d  = sum[NUM_BITS];
          rs_d = {sum[NUM_BITS-1:0], rs_q[NUM_BITS-1:0]};
        end
        2'b01: begin
          c_d  = 1'b0;
          rs_d = {c_q, rs_q[2*NUM_BITS-1:1]};
          ns_d = ns_inc;
        end
        2'b11: begin
          // Fused add-then-shift: the sum's carry becomes the new RS MSB.
          c_d  = 1'b0;
          rs_d = {sum, rs_q[NUM_BITS-1:1]};
          ns_d = ns_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_q <= '0;
      mr_q <= '0;
      rs_q <= '0;
      c_q  <= 1'b0;
      ns_q <= '0;
    end else begin
      md_q <= md_d;
      mr_q <= mr_d;
      rs_q <= rs_d;
      c_q  <= c_d;
      ns_q <= ns_d;
    end
  end

`ifdef SM_DP_PROTOCOL_CHECK_EN
  logic err_q, err_d;

  // Sticky until rst; rsclear deliberately leaves it alone.
  always_comb begin
    err_d = err_q
          | (bus.rsshr  && (ns_q == NS_MAX))
          | (bus.rsload && bus.rsclear)
          | (bus.mdld   && bus.rsload);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.mr      = mr_q;
  assign bus.product = rs_q;
  assign bus.nshift  = ns_q;
endmodule

// File: tb/tb_sm_datapath.sv
// tb/tb_sm_datapath.sv - self-checking bench for sm_datapath against an arithmetic reference model
module tb_sm_datapath;
  localparam int N = 4;
  localparam int W = 2 * N;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sm_datapath_if #(.NUM_BITS(N)) bus ();

  sm_datapath #(.NUM_BITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

`ifdef SM_DP_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Reference state: {C,RS} kept as one integer value of 2N+1 bits.
  int unsigned m_md, m_mr, m_val, m_ns;
  bit          m_err;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle with the given strobes, then model update and output check.
  task automatic cyc(input int unsigned mdi, input int unsigned mri,
                     input bit ld_md, input bit ld_mr, input bit ld,
                     input bit clr, input bit shr, input bit r);
    bus.md_in   = mdi[N-1:0];
    bus.mr_in   = mri[N-1:0];
    bus.mdld    = ld_md;
    bus.mrld    = ld_mr;
    bus.rsload  = ld;
    bus.rsclear = clr;
    bus.rsshr   = shr;
    rst         = r;
    @(posedge clk);
    if (r) begin
      m_md = 0; m_mr = 0; m_val = 0; m_ns = 0; m_err = 0;
    end else begin
      if (CHK && ((shr && m_ns == N) || (ld && clr) || (ld_md && ld))) m_err = 1;
      if (clr) begin
        m_val = 0;
        m_ns  = 0;
      end else begin
        if (ld) m_val = (m_val % (1 << W)) + m_md * (1 << N);
        if (shr) begin
          m_val = m_val / 2;
          if (m_ns < N) m_ns++;
        end
      end
      if (ld_md) m_md = mdi % (1 << N);
      if (ld_mr) m_mr = mri % (1 << N);
    end
    #1;
    check_eq("product", bus.product, m_val % (1 << W));
    check_eq("mr", bus.mr, m_mr);
    check_eq("nshift", bus.nshift, m_ns);
    check_eq("err", bus.err, m_err);
    bus.mdld = 0; bus.mrld = 0; bus.rsload = 0; bus.rsclear = 0; bus.rsshr = 0;
    rst = 0;
  endtask

  task automatic do_mult(input int unsigned a, input int unsigned b, input bit fused);
    cyc(a, b, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < N; i++) begin
      if (fused) cyc(0, 0, 0, 0, b[i], 0, 1, 0);
      else begin
        if (b[i]) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
      end
    end
    check_eq("mult_product", bus.product, a * b);
  endtask

  initial begin
    bus.md_in = 0; bus.mr_in = 0; bus.mdld = 0; bus.mrld = 0;
    bus.rsload = 0; bus.rsclear = 0; bus.rsshr = 0;
    m_md = 0; m_mr = 0; m_val = 0; m_ns = 0; m_err = 0;

    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("rst_product", bus.product, 0);
    check_eq("rst_err", bus.err, 0);

    // Basic multiply 13*11
    do_mult(13, 11, 0);
    check_eq("basic_product", bus.product, 143);
    check_eq("basic_nshift", bus.nshift, 4);
    check_eq("basic_mr", bus.mr, 11);
    check_eq("basic_err", bus.err, 0);

    // Carry path with fused strobes
    cyc(15, 15, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 0);
    check_eq("carry_first", bus.product, 8'h78);
    for (int i = 1; i < N; i++) cyc(0, 0, 0, 0, 1, 0, 1, 0);
    check_eq("carry_product", bus.product, 225);

    // Priority: clear beats load and shift
    cyc(0, 0, 0, 0, 1, 1, 1, 0);
    check_eq("prio_product", bus.product, 0);
    check_eq("prio_nshift", bus.nshift, 0);
    check_eq("prio_err", bus.err, CHK);

    // Reset mid-multiply, then rerun
    cyc(9, 7, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("midrst_product", bus.product, 0);
    check_eq("midrst_mr", bus.mr, 0);
    check_eq("midrst_nshift", bus.nshift, 0);
    check_eq("midrst_err", bus.err, 0);
    do_mult(9, 7, 0);
    check_eq("rerun_product", bus.product, 63);

    // Load ordering: adder uses the old MD
    cyc(3, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(5, 0, 1, 0, 1, 0, 0, 0);
    check_eq("ldord_upper", bus.product >> N, 3);
    check_eq("ldord_err", bus.err, CHK);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // Over-shift and err stickiness
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("ovr_nshift", bus.nshift, 4);
    check_eq("ovr_err", bus.err, CHK);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    check_eq("ovr_err_after_clear", bus.err, CHK);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("ovr_err_after_rst", bus.err, 0);

    // Random full multiplies
    for (int k = 0; k < 20; k++)
      do_mult($urandom_range(0, (1 << N) - 1), $urandom_range(0, (1 << N) - 1), k[0]);

    // Random strobe soup against the model
    for (int k = 0; k < 400; k++) begin
      cyc($urandom, $urandom,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 1) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/sm_datapath.md
# sm_datapath

Shift-and-add multiplier datapath. It is the responder for the strobes issued by `SMControl`. It holds the multiplicand (MD), the multiplier (MR) and the running-sum (RS) registers, plus the RS adder and carry. It returns `mr` to the controller and presents the 2·NUM_BITS product. Every register updates only on a controller strobe sampled at a rising clock edge.

## Interface
- `NUM_BITS`, default 4: operand width. Legal range is 2..16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `md_in`  in  NUM_BITS  multiplicand source value.
- `mr_in`  in  NUM_BITS  multiplier source value.
- `mdld`  in  1  load MD from `md_in`.
- `mrld`  in  1  load MR from `mr_in`.
- `rsload`  in  1  add MD into the RS upper half.
- `rsclear`  in  1  clear RS, the carry and the shift count.
- `rsshr`  in  1  shift {carry, RS} right by one.
- `mr`  out  NUM_BITS  MR register contents; the controller reads this.
- `product`  out  2·NUM_BITS  RS register contents.
- `nshift`  out  $clog2(NUM_BITS+1)  count of `rsshr` strobes since the last clear. Saturates at NUM_BITS.
- `err`  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- State:
  - MD[NUM_BITS]
  - MR[NUM_BITS]
  - RS[2·NUM_BITS]
  - carry C[1]
  - shift counter
  - err flag
- `mdld` and `mrld` are independent of each other and of the RS strobes. Both may assert in the same cycle.
- RS strobe priority is rsclear > (rsload, rsshr).
  - rsclear: RS←0, C←0, nshift←0. Any rsload or rsshr in the same cycle is ignored.
  - rsload only: {C, RS[2N-1:N]} ← RS[2N-1:N] + MD, computed as an (N+1)-bit sum. RS[N-1:0] is unchanged.
  - rsshr only: {C, RS} ← {0, C, RS[2N-1:1]}. nshift increments and saturates at NUM_BITS.
  - rsload and rsshr together: a fused add-then-shift. The (N+1)-bit sum and RS[N-1:1] are shifted in one edge, and nshift increments.
- Adder operands are the register values before the edge. MD loaded in cycle k is therefore used by rsload from cycle k+1 onward.
- The sequence RS clear, then NUM_BITS iterations of (rsload if MR bit i, then rsshr) for i = 0..N-1, leaves `product` = MD·MR exactly. There is no truncation and the result never exceeds 2N bits.
- MR is never modified by the RS strobes. The controller indexes MR bits itself.

## Timing
- Reset values: MD=0, MR=0, RS=0, C=0, nshift=0, `mr`=0, `product`=0, `err`=0.
- `rst` overrides every strobe in the same cycle.
- Reset applied mid-multiply aborts the operation. All state returns to reset values on that edge.
- All outputs come straight from registers. A strobe sampled at edge k is visible on the outputs after edge k, with 1-cycle latency.
- There is no combinational path from the strobe inputs to any output.
- Strobes are level-sampled each edge. A strobe held high for m cycles takes effect m times:
  - rsload held high adds MD repeatedly.
  - rsshr held high shifts repeatedly.

## Configuration
- `SM_DP_PROTOCOL_CHECK_EN` defined: `err` sets on any of the following and stays set until `rst`:
  - `rsshr` asserted while nshift == NUM_BITS (shift past operand width);
  - `rsload` and `rsclear` asserted together;
  - `mdld` asserted in the same cycle as `rsload`.
- `rsclear` does not clear `err`.
- Datapath behaviour is identical with or without the macro.
- Macro undefined: `err` is tied to 0 and no checker logic is synthesized.

## Test plan
- Basic multiply, NUM_BITS=4, md_in=13, mr_in=11.
  - Stimulus: mdld+mrld, then rsclear, then for bits 1,1,0,1 apply (rsload if bit) followed by rsshr.
  - Required: product=8'h8F (143), nshift=4, mr=4'hB, err=0.
- Carry path: md=15, mr=15, using the fused rsload+rsshr strobe every iteration.
  - Required: product=8'hE1 (225).
  - Required: after the first fused strobe, RS=8'h78 and C=0.
- Priority: RS nonzero, then rsclear+rsload+rsshr in one cycle.
  - Required next cycle: product=0, nshift=0.
- Reset mid-multiply: after 2 iterations of md=9, mr=7, assert rst.
  - Required next cycle: product=0, mr=0, nshift=0, err=0.
  - Required: a full rerun of the sequence yields product=63.
- Load ordering: mdld(md_in=5) in the same cycle as rsload, with MD previously 3, from a cleared RS.
  - Required: RS upper half=3, and err=1 only when `SM_DP_PROTOCOL_CHECK_EN` is defined.
- Over-shift: 5 consecutive rsshr after rsclear.
  - Required: nshift stays 4, and err=1 with the macro or err=0 without it.
  - Required: err remains set through a subsequent rsclear and clears only on rst.
